gelato_compute_alu: RTL and testbench

GELATO_COMPUTE_ALU -- requirements
Module: gelato_compute_alu

---
 rtl/gelato_compute_alu.sv | 160 ++++++++++++++++
 tb/tb_gelato_compute_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_compute_alu.sv
// SIMT lane ALU: latches one task, evaluates LANES_PER_CYCLE lanes per cycle, then holds a writeback packet.
// Define GELATO_ALU_MUL_EN to build the per-lane multipliers (op 10); otherwise op 10 is treated as illegal.
module gelato_compute_alu #(
    parameter int THREAD_NUM      = 32,
    parameter int LANES_PER_CYCLE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      task_valid,
    output logic                      task_ready,
    input  logic [3:0]                task_op,
    input  logic [4:0]                task_rd,
    input  logic [THREAD_NUM-1:0]     task_mask,
    input  logic [THREAD_NUM*32-1:0]  task_rs1,
    input  logic [THREAD_NUM*32-1:0]  task_rs2,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [4:0]                wb_rd,
    output logic [THREAD_NUM-1:0]     wb_mask,
    output logic [THREAD_NUM*32-1:0]  wb_data,
    output logic                      err_illegal_op
);

    localparam int GROUPS = THREAD_NUM / LANES_PER_CYCLE;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_WRITEBACK
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_t;

    function automatic logic op_is_illegal(input logic [3:0] op);
`ifdef GELATO_ALU_MUL_EN
        return op > OP_MUL;
`else
        return op >= OP_MUL;
`endif
    endfunction

    function automatic logic [31:0] lane_eval(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: r = {31'b0, a < b};
`ifdef GELATO_ALU_MUL_EN
            OP_MUL:  r = a * b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t                                       state;
    logic [GW-1:0]                                grp_q;
    logic [3:0]                                   op_q;
    logic                                         illegal_q;
    logic [4:0]                                   rd_q;
    logic [GROUPS-1:0][LANES_PER_CYCLE-1:0]       mask_q;
    logic [GROUPS-1:0][LANES_PER_CYCLE-1:0][31:0] rs1_q;
    logic [GROUPS-1:0][LANES_PER_CYCLE-1:0][31:0] rs2_q;
    logic [GROUPS-1:0][LANES_PER_CYCLE-1:0][31:0] res_q;
    logic [LANES_PER_CYCLE-1:0][31:0]             grp_res;
    logic                                         accept;

    assign task_ready = (state == S_IDLE);
    assign accept     = task_ready && task_valid;
    assign wb_data    = res_q;

    // NOTE: operand latches carry no reset; they are only observed after a fresh accept overwrites them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= task_op;
            illegal_q <= op_is_illegal(task_op);
            rd_q      <= task_rd;
            mask_q    <= task_mask;
            rs1_q     <= task_rs1;
            rs2_q     <= task_rs2;
        end
    end

    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        grp_res = '0;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            if (mask_q[grp_q][j] && !illegal_q) begin
                grp_res[j] = lane_eval(op_q, rs1_q[grp_q][j], rs2_q[grp_q][j]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            grp_q          <= '0;
            res_q          <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_mask        <= '0;
            err_illegal_op <= 1'b0;
        end else begin
            err_illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (task_valid) begin
                        grp_q          <= '0;
                        err_illegal_op <= op_is_illegal(task_op);
                        state          <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    res_q[grp_q] <= grp_res;
                    grp_q        <= grp_q + 1'b1;
                    if (grp_q == GW'(GROUPS - 1)) begin
                        grp_q    <= '0;
                        state    <= S_WRITEBACK;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        // Writes to x0 and illegal ops leave the register file untouched.
                        wb_mask  <= (rd_q == 5'd0 || illegal_q) ? '0 : mask_q;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gelato_compute_alu.sv
// Self-checking bench for gelato_compute_alu: directed corner cases plus randomized tasks against a lane-level model.
module tb_gelato_compute_alu;

    localparam int TN  = 32;
    localparam int LPC = 8;
    localparam int G   = TN / LPC;
`ifdef GELATO_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              task_valid;
    logic              task_ready;
    logic [3:0]        task_op;
    logic [4:0]        task_rd;
    logic [TN-1:0]     task_mask;
    logic [TN*32-1:0]  task_rs1;
    logic [TN*32-1:0]  task_rs2;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_rd;
    logic [TN-1:0]     wb_mask;
    logic [TN*32-1:0]  wb_data;
    logic              err_illegal_op;

    int tests = 0;
    int fails = 0;

    gelato_compute_alu #(.THREAD_NUM(TN), .LANES_PER_CYCLE(LPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .task_valid(task_valid), .task_ready(task_ready), .task_op(task_op), .task_rd(task_rd),
        .task_mask(task_mask), .task_rs1(task_rs1), .task_rs2(task_rs2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_mask(wb_mask),
        .wb_data(wb_data), .err_illegal_op(err_illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_lane(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return $unsigned($signed(a) >>> sh);
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input int op);
        return (op <= 9) || (op == 10 && MUL_EN);
    endfunction

    task automatic scramble_inputs(input bit valid);
        task_valid = valid;
        task_op    = 4'($urandom);
        task_rd    = 5'($urandom);
        task_mask  = TN'($urandom);
        for (int i = 0; i < TN; i++) begin
            task_rs1[i*32 +: 32] = $urandom;
            task_rs2[i*32 +: 32] = $urandom;
        end
    endtask

    // Offer one task, follow it to writeback, stall wb_ready for 'hold' cycles, then hand it off.
    task automatic run_task(input int op, input logic [4:0] rd, input logic [TN-1:0] mask,
                            input logic [TN*32-1:0] a, input logic [TN*32-1:0] b,
                            input int hold, input bit offer_during_hold);
        logic [TN*32-1:0] exp_data;
        logic [TN-1:0]    exp_mask;
        bit               legal;
        int               cyc;

        legal = ref_legal(op);
        for (int i = 0; i < TN; i++)
            exp_data[i*32 +: 32] = (legal && mask[i]) ? ref_lane(op, a[i*32 +: 32], b[i*32 +: 32]) : 32'd0;
        exp_mask = (legal && rd != 5'd0) ? mask : '0;

        cyc = 0;
        while (!task_ready && cyc < 100) begin
            step();
            cyc++;
        end
        check("task_ready_idle", task_ready, 1'b1);

        task_valid = 1'b1;
        task_op    = 4'(op);
        task_rd    = rd;
        task_mask  = mask;
        task_rs1   = a;
        task_rs2   = b;
        step();
        scramble_inputs(1'b0);
        check("err_pulse", err_illegal_op, !legal);
        check("busy_after_accept", task_ready, 1'b0);

        cyc = 0;
        while (!wb_valid && cyc < 50) begin
            step();
            cyc++;
            if (cyc == 1) check("err_clear", err_illegal_op, 1'b0);
        end
        check("wb_latency", cyc, G);

        for (int i = 0; i < TN; i++)
            check($sformatf("wb_data_lane%0d", i), wb_data[i*32 +: 32], exp_data[i*32 +: 32]);

        for (int h = 0; h <= hold; h++) begin
            check("wb_valid_hold", wb_valid, 1'b1);
            check("wb_rd_hold", wb_rd, rd);
            check("wb_mask_hold", wb_mask, exp_mask);
            check("wb_data_hold", wb_data === exp_data, 1'b1);
            check("no_accept_busy", task_ready, 1'b0);
            if (offer_during_hold) scramble_inputs(1'b1);
            if (h == hold) wb_ready = 1'b1;
            step();
        end
        wb_ready   = 1'b0;
        task_valid = 1'b0;
        check("wb_valid_drop", wb_valid, 1'b0);
        check("ready_after_hs", task_ready, 1'b1);
    endtask

    task automatic fill(output logic [TN*32-1:0] v, input logic [31:0] val);
        for (int i = 0; i < TN; i++) v[i*32 +: 32] = val;
    endtask

    initial begin
        logic [TN*32-1:0] a;
        logic [TN*32-1:0] b;
        int               cyc;

        rst_n      = 1'b0;
        wb_ready   = 1'b0;
        task_valid = 1'b0;
        task_op    = '0;
        task_rd    = '0;
        task_mask  = '0;
        task_rs1   = '0;
        task_rs2   = '0;
        step();
        check("rst_task_ready", task_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_mask", wb_mask, '0);
        check("rst_wb_data_zero", wb_data === '0, 1'b1);
        check("rst_err", err_illegal_op, 1'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < TN; i++) begin
            a[i*32 +: 32] = 32'(i);
            b[i*32 +: 32] = 32'd100;
        end
        run_task(0, 5'd3, '1, a, b, 0, 1'b0);

        fill(a, 32'd0);
        fill(b, 32'd1);
        run_task(1, 5'd4, 32'h0000_FFFF, a, b, 1, 1'b0);

        fill(a, 32'h8000_0000);
        fill(b, 32'h24);
        run_task(7, 5'd6, '1, a, b, 0, 1'b0);
        fill(a, 32'hFFFF_FFFF);
        fill(b, 32'd1);
        run_task(8, 5'd6, '1, a, b, 0, 1'b0);
        run_task(9, 5'd6, '1, a, b, 0, 1'b0);

        run_task(12, 5'd5, '1, a, b, 0, 1'b0);
        fill(a, 32'd7);
        fill(b, 32'd6);
        run_task(10, 5'd8, '1, a, b, 0, 1'b0);

        // Stall writeback while a second task is offered, then a task targeting x0.
        fill(a, 32'h1234_5678);
        fill(b, 32'h0F0F_0F0F);
        run_task(4, 5'd7, 32'hA5A5_5A5A, a, b, 10, 1'b1);
        run_task(2, 5'd0, '1, a, b, 2, 1'b0);

        // Reset in the second compute cycle aborts the task.
        task_valid = 1'b1;
        task_op    = 4'd0;
        task_rd    = 5'd9;
        task_mask  = '1;
        task_rs1   = a;
        task_rs2   = b;
        step();
        task_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("abort_wb_valid", wb_valid, 1'b0);
        check("abort_task_ready", task_ready, 1'b1);
        check("abort_wb_mask", wb_mask, '0);
        check("abort_wb_data_zero", wb_data === '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", task_ready, 1'b1);
        cyc = 0;
        for (int k = 0; k < 2 * G + 2; k++) begin
            if (wb_valid) cyc++;
            step();
        end
        check("abort_no_writeback", cyc, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < TN; i++) begin
                a[i*32 +: 32] = $urandom;
                b[i*32 +: 32] = $urandom;
            end
            run_task(int'($urandom_range(15, 0)), 5'($urandom), TN'($urandom), a, b,
                     int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
